// File: rtl/sdlc_rx_deframer.sv
// SDLC receive deframer: flag hunt, zero-bit destuffing, LSB-first byte assembly,
// CRC-16/X-25 residue check, abort detection and a one-byte output register.
module sdlc_rx_deframer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_FRAME   = 4,
  parameter logic [15:0] CRC_RESIDUE = 16'hF0B8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_clk,
  input  logic       rx_data,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       frame_done,
  output logic       frame_crc_ok,
  output logic       frame_err,
  output logic       rx_abort,
  output logic       overrun
);

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [7:0]  FLAG     = 8'h7E;

  typedef enum logic {S_HUNT, S_ACTIVE} state_t;

  state_t                 r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic [7:0]             r_raw8, r_dsr, r_hold, r_bytecnt, r_dout;
  logic [2:0]             r_ones, r_bitcnt;
  logic [15:0]            r_crc;
  logic                   r_hold_v, r_dout_valid, r_dout_last;
  logic                   r_frame_done, r_crc_ok, r_frame_err, r_abort, r_overrun;

  logic       w_evt, w_bit, w_flag, w_abort_bit, w_stuff, w_ferr;
  logic [7:0] w_raw8_n, w_byte;
  logic [2:0] w_ones_n;
  logic       w_data, w_clear, w_close, w_abort, w_push, w_push_last;

  // Reflected CRC-16 (0x8408) advanced over one byte.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign w_evt       = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_bit       = r_dat_sync[SYNC_STAGES-1];
  assign w_raw8_n    = {w_bit, r_raw8[7:1]};
  assign w_flag      = (w_raw8_n == FLAG);
  assign w_abort_bit = w_bit && (r_ones == 3'd6);
  assign w_stuff     = !w_bit && (r_ones == 3'd5);
  assign w_ones_n    = !w_bit ? 3'd0 : ((r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1);
  assign w_byte      = {w_bit, r_dsr[7:1]};
  assign w_ferr      = (r_bitcnt != 3'd7) || (r_bytecnt < 8'(MIN_FRAME));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_HUNT;
    else          r_state <= w_state_n;
  end

  // Per-bit decisions; the flag check wins over abort and destuffing.
  always_comb begin
    w_state_n   = r_state;
    w_data      = 1'b0;
    w_clear     = 1'b0;
    w_close     = 1'b0;
    w_abort     = 1'b0;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    if (w_evt) begin
      case (r_state)
        S_HUNT: begin
          if (w_flag) begin
            w_state_n = S_ACTIVE;
            w_clear   = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_flag) begin
            w_clear = 1'b1;
            if (r_bytecnt != 8'd0) begin
              w_close = 1'b1;
              if (!w_ferr && r_hold_v) begin
                w_push      = 1'b1;
                w_push_last = 1'b1;
              end
            end
          end else if (w_abort_bit) begin
            w_state_n = S_HUNT;
            w_clear   = 1'b1;
            w_abort   = (r_bytecnt != 8'd0);
          end else if (!w_stuff) begin
            w_data = 1'b1;
            w_push = (r_bitcnt == 3'd7) && r_hold_v;
          end
        end
        default: w_state_n = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
      r_raw8     <= 8'h00;
      r_ones     <= 3'd0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], rx_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], rx_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      if (w_evt) begin
        r_raw8 <= w_raw8_n;
        r_ones <= w_ones_n;
      end
    end
  end

  // Byte assembly, CRC, one-byte holdback that keeps the final FCS byte until the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dsr     <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_bytecnt <= 8'd0;
      r_hold    <= 8'h00;
      r_hold_v  <= 1'b0;
      r_crc     <= CRC_INIT;
    end else if (w_clear) begin
      r_bitcnt  <= 3'd0;
      r_bytecnt <= 8'd0;
      r_hold_v  <= 1'b0;
      r_crc     <= CRC_INIT;
    end else if (w_data) begin
      r_dsr    <= w_byte;
      r_bitcnt <= r_bitcnt + 3'd1;
      if (r_bitcnt == 3'd7) begin
        r_crc    <= crc_byte(r_crc, w_byte);
        r_hold   <= w_byte;
        r_hold_v <= 1'b1;
        if (r_bytecnt != 8'hFF) r_bytecnt <= r_bytecnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_overrun    <= 1'b0;
      r_frame_done <= w_close;
      r_abort      <= w_abort;
      if (w_close) begin
        r_frame_err <= w_ferr;
        r_crc_ok    <= !w_ferr && (r_crc == CRC_RESIDUE);
      end
      if (w_push && r_dout_valid && !dout_ready) begin
        r_overrun <= 1'b1;
      end else if (w_push) begin
        r_dout       <= r_hold;
        r_dout_last  <= w_push_last;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign dout_last    = r_dout_last;
  assign frame_done   = r_frame_done;
  assign frame_crc_ok = r_crc_ok;
  assign frame_err    = r_frame_err;
  assign rx_abort     = r_abort;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sdlc_rx_deframer.sv
// Directed bench for sdlc_rx_deframer: frames are modelled from their unstuffed
// bit content, then stuffed and serialized onto rx_clk/rx_data.
module tb_sdlc_rx_deframer;

  localparam int unsigned MIN_FRAME = 4;
  localparam logic [15:0] RESIDUE   = 16'hF0B8;

  logic       clk = 1'b0;
  logic       reset_n, rx_clk, rx_data, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, dout_last, frame_done, frame_crc_ok, frame_err, rx_abort, overrun;

  int n_vec = 0;
  int n_err = 0;
  bit         content[$];
  logic [7:0] payload[$];
  logic [8:0] exp_out[$];
  logic [1:0] exp_stat[$];
  int exp_aborts = 0, exp_ovr = 0, seen_aborts = 0, seen_ovr = 0;
  logic [15:0] last_fcs;

  sdlc_rx_deframer dut (
    .clk(clk), .reset_n(reset_n), .rx_clk(rx_clk), .rx_data(rx_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .frame_done(frame_done), .frame_crc_ok(frame_crc_ok), .frame_err(frame_err),
    .rx_abort(rx_abort), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Bit-serial reference CRC over whole bytes, LSB first.
  function automatic logic [15:0] crc_bits(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic add_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) content.push_back(b[k]);
    payload.push_back(b);
  endtask

  task automatic add_fcs();
    logic [15:0] f;
    f = ~crc_bits(payload);
    last_fcs = f;
    add_byte(f[7:0]);
    add_byte(f[15:8]);
  endtask

  task automatic tx_bit(input logic b);
    rx_data = b;
    #40 rx_clk = 1'b1;
    #40 rx_clk = 1'b0;
  endtask

  task automatic tx_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int k = 0; k < 8; k++) tx_bit(f[k]);
  endtask

  task automatic tx_content();
    int ones;
    ones = 0;
    foreach (content[i]) begin
      tx_bit(content[i]);
      if (content[i]) begin
        ones++;
        if (ones == 5) begin
          tx_bit(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  // Expected outputs: the receiver sees content plus the leading 7 bits of the
  // terminating flag (or 6 ones before an abort) as data; every completed byte
  // but the last is delivered, the last only on an aligned, long-enough frame.
  task automatic model_frame(input bit by_abort, input bit ready_low);
    bit         d[$];
    logic [7:0] b[$];
    logic [7:0] cur;
    int         n, pushes;
    bit         err;
    d = content;
    if (!by_abort) d.push_back(1'b0);
    repeat (6) d.push_back(1'b1);
    n = d.size() / 8;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) cur[k] = d[8*i+k];
      b.push_back(cur);
    end
    if (n == 0) return;
    err = by_abort || ((d.size() % 8) != 7) || (n < MIN_FRAME);
    pushes = 0;
    for (int i = 0; i < n; i++) begin
      if (i < n - 1 || !err) begin
        if (!ready_low || pushes == 0) exp_out.push_back({(i == n - 1), b[i]});
        pushes++;
      end
    end
    if (ready_low && pushes > 0) exp_ovr += pushes - 1;
    if (by_abort) exp_aborts++;
    else exp_stat.push_back({(!err && (crc_bits(b) == RESIDUE)), err});
  endtask

  task automatic send_frame(input bit ready_low);
    model_frame(1'b0, ready_low);
    tx_flag();
    tx_content();
    tx_flag();
    content.delete();
    payload.delete();
  endtask

  task automatic send_abort_frame();
    model_frame(1'b1, 1'b0);
    tx_flag();
    tx_content();
    repeat (8) tx_bit(1'b1);
    content.delete();
    payload.delete();
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout_last"}, 32'(dout_last), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_crc_ok"}, 32'(frame_crc_ok), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_rx_abort"}, 32'(rx_abort), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Compare process: every accepted byte and every frame status against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid && dout_ready) begin
        if (exp_out.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h last=%0b, required no byte", dout, dout_last);
        end else begin
          check("dout_last_byte", {23'd0, dout_last, dout}, {23'd0, exp_out.pop_front()});
        end
      end
      if (frame_done) begin
        if (exp_stat.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame_done: got pulse, required none");
        end else begin
          check("crc_ok_err", {30'd0, frame_crc_ok, frame_err}, {30'd0, exp_stat.pop_front()});
        end
      end
      if (rx_abort) seen_aborts++;
      if (overrun) seen_ovr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    rx_clk     = 1'b0;
    rx_data    = 1'b1;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #3;
    repeat (10) tx_bit(1'b1);
    tx_flag();

    for (int i = 0; i < 9; i++) add_byte(8'h31 + 8'(i));
    add_fcs();
    check("model_fcs", 32'(last_fcs), 32'h906E);
    check("model_residue", 32'(crc_bits(payload)), 32'(RESIDUE));
    send_frame(1'b0);
    settle();
    check("f1_crc_ok", 32'(frame_crc_ok), 32'd1);
    check("f1_err", 32'(frame_err), 32'd0);

    for (int i = 0; i < 9; i++) add_byte(8'h31 + 8'(i));
    add_byte(8'h6F);
    add_byte(8'h90);
    send_frame(1'b0);
    settle();
    check("badfcs_crc_ok", 32'(frame_crc_ok), 32'd0);
    check("badfcs_err", 32'(frame_err), 32'd0);

    add_byte(8'hFF);
    add_byte(8'h7E);
    add_byte(8'h3F);
    add_fcs();
    send_frame(1'b0);
    settle();
    check("stuffed_crc_ok", 32'(frame_crc_ok), 32'd1);

    add_byte(8'h11);
    add_byte(8'h22);
    add_byte(8'h33);
    send_abort_frame();
    tx_flag();
    add_byte(8'hA1);
    add_byte(8'hB2);
    add_byte(8'hC3);
    add_fcs();
    send_frame(1'b0);
    settle();
    check("abort_seen", 32'(seen_aborts), 32'd1);
    check("after_abort_crc_ok", 32'(frame_crc_ok), 32'd1);

    add_byte(8'h55);
    add_byte(8'hAA);
    add_fcs();
    content.push_back(1'b1);
    content.push_back(1'b0);
    content.push_back(1'b1);
    send_frame(1'b0);
    settle();
    check("misalign_err", 32'(frame_err), 32'd1);
    check("misalign_crc_ok", 32'(frame_crc_ok), 32'd0);

    add_byte(8'h12);
    add_byte(8'h34);
    send_frame(1'b0);
    settle();
    check("short_err", 32'(frame_err), 32'd1);

    @(posedge clk);
    #1 dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) add_byte(8'(i));
    add_fcs();
    send_frame(1'b1);
    settle();
    check("hold_valid", 32'(dout_valid), 32'd1);
    check("hold_byte", 32'(dout), 32'h01);
    check("hold_last", 32'(dout_last), 32'd0);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    settle();
    check("overrun_seen", 32'(seen_ovr), 32'd5);
    check("drained_valid", 32'(dout_valid), 32'd0);
    check("pre_reset_crc_ok", 32'(frame_crc_ok), 32'd1);

    tx_flag();
    add_byte(8'hA5);
    content.push_back(1'b1);
    content.push_back(1'b0);
    content.push_back(1'b1);
    content.push_back(1'b1);
    tx_content();
    content.delete();
    payload.delete();
    settle();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    #3;
    repeat (10) tx_bit(1'b1);
    add_byte(8'h5A);
    add_byte(8'hC3);
    add_byte(8'h0F);
    add_fcs();
    send_frame(1'b0);
    settle();
    check("post_reset_crc_ok", 32'(frame_crc_ok), 32'd1);

    for (int i = 0; i < 200 && (exp_out.size() != 0 || exp_stat.size() != 0); i++) @(negedge clk);
    #1;
    check("pending_bytes", 32'(exp_out.size()), 32'd0);
    check("pending_status", 32'(exp_stat.size()), 32'd0);
    check("abort_count", 32'(seen_aborts), 32'(exp_aborts));
    check("overrun_count", 32'(seen_ovr), 32'(exp_ovr));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdlc_rx_deframer.md
Name: sdlc_rx_deframer

Overview:
- Receive half of the SDLC link, the counterpart of the datapath TX engine (flag insertion, zero-bit stuffing, CRC-16 append).
- Samples rx_data on external rx_clk rising edges, all logic in the clk domain.
- Hunts for 0x7E flags, removes stuffed zeros and assembles LSB-first bytes.
- Checks FCS and detects aborts; delivers payload+FCS bytes over a valid/ready handshake, frame status after the closing flag.

Parameters:
SYNC_STAGES, 2, synchronizer flops on rx_clk and rx_data (min 2)
MIN_FRAME, 4, minimum completed bytes (FCS included) for a valid frame
CRC_RESIDUE, 16'hF0B8, good-frame residue of CRC-16/X-25 run over payload+FCS

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_clk  in  1  line clock, asynchronous to clk
rx_data  in  1  line data, valid at rx_clk rising edge
dout  out  8  received byte
dout_valid  out  1  dout holds a byte (also DMA request)
dout_ready  in  1  consumer accepts dout this cycle
dout_last  out  1  dout is final byte of a frame (second FCS byte)
frame_done  out  1  one-cycle pulse at closing flag of a non-empty frame
frame_crc_ok  out  1  level, residue matched in last completed frame
frame_err  out  1  level, last frame misaligned or shorter than MIN_FRAME
rx_abort  out  1  one-cycle pulse, abort (7 ones) inside a frame
overrun  out  1  one-cycle pulse, byte dropped because dout still full

Behaviour:
- Reset: all outputs 0, state HUNT, CRC=16'hFFFF, counters 0. Takes effect immediately, also mid-frame; in-flight frame discarded, no status.
- rx_clk and rx_data pass through SYNC_STAGES flops. A 0->1 on synchronized rx_clk is a bit event; the bit is synchronized rx_data of the same stage. One bit processed per event.
- raw8: last 8 raw bits, shifted in at MSB. ones: run of 1s, saturates at 7, cleared by a 0.
- Flag: raw8==8'h7E. Takes priority over destuffing.
- Abort: bit=1 making ones==7.
- Stuffed zero: bit=0 with ones==5 before it. Discarded in ACTIVE.
- States:
  - HUNT: on flag -> ACTIVE, clear bitcnt, bytecnt, holdback; CRC=FFFF.
  - ACTIVE, data bit: shift into dsr (MSB in, shift right), bitcnt++.
  - Byte completion (bitcnt 7->0): byte=dsr; CRC updated bytewise (poly 0x8408 reflected); bytecnt++ (saturate 255).
    - If holdback valid: push holdback to output, last=0.
    - Holdback <= byte.
  - ACTIVE, flag with bytecnt==0: inter-frame or shared-zero flag; silent restart.
  - ACTIVE, flag with bytecnt>0: frame_done pulse.
    - frame_err = (bitcnt!=7) | (bytecnt<MIN_FRAME).
    - frame_crc_ok = !frame_err & (CRC==CRC_RESIDUE).
    - If !frame_err: push holdback with last=1; else discard it.
    - Re-arm: counters clear, CRC=FFFF, stay ACTIVE.
  - ACTIVE, abort: if bytecnt>0, rx_abort pulse; holdback discarded; -> HUNT. HUNT ignores aborts and idle ones.
- Output push:
  - Sets dout/dout_last/dout_valid on the next clk edge.
  - dout_valid falls the cycle after dout_valid&dout_ready.
  - Push while dout_valid & !dout_ready: new byte dropped, held byte kept, overrun pulse.
  - Push in the same cycle as acceptance: new byte loaded, no overrun.
- Latency: rx_clk rising edge at pins -> dout_valid/frame_done after SYNC_STAGES+2 clk max.
- FCS bytes are delivered; the consumer strips them via dout_last.
- frame_crc_ok/frame_err hold until the next frame_done.

Test Plan:
- Flags, then "123456789" (0x31..0x39), FCS 0x6E,0x90 LSB-first, flag; dout_ready=1. Required: 11 bytes 31..39,6E,90, dout_last only on 0x90; frame_done; frame_crc_ok=1, frame_err=0.
- Same frame with FCS 0x6F,0x90. Required: 11 bytes delivered, frame_crc_ok=0, frame_err=0.
- Payload 0xFF,0x7E,0x3F plus correct FCS, sent stuffed. Required: dout FF,7E,3F unaltered; no false flag; crc_ok=1.
- Mid-frame after 3 bytes, 8 consecutive 1s. Required: rx_abort pulse, no dout_last, no frame_done; back-to-back 7E 7E then good frame decodes.
- Frame with 3 extra data bits before closing flag. Required: frame_err=1, crc_ok=0, held byte not delivered. Frame of 2 bytes: frame_err=1.
- dout_ready=0 for a full frame. Required: first byte held, overrun pulses for each later push. reset_n low mid-frame: all outputs 0 at once, HUNT.
